// File: rtl/stopwatch_time_counter.sv
// ============================================================================
// Module   : stopwatch_time_counter
// Brief    : Hundredths timebase and SS.hh BCD counter with a lap-freeze display
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_time_counter #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init_regs,
  input  logic        count_enabled,
  input  logic        split,
  output logic [15:0] disp_digits,
  output logic        frozen,
  output logic        wrap
);

  localparam int                c_DIV       = CLK_FREQ_HZ / TICK_HZ;
  localparam int                c_PW        = $clog2(c_DIV);
  localparam logic [c_PW-1:0]   c_PRESC_MAX = c_PW'(c_DIV - 1);

  logic [c_PW-1:0] r_presc;
  logic [15:0]     r_live;
  logic [15:0]     r_snap;
  logic            r_frozen;
  logic            r_wrap;

  logic            w_tick;
  logic [15:0]     w_inc;
  logic            w_rollover;

  assign w_tick = count_enabled && (r_presc == c_PRESC_MAX);

  // Ripple-carry BCD increment; sec_tens wraps at 5 to give 59.99 -> 00.00.
  always_comb begin
    w_inc      = r_live;
    w_rollover = 1'b0;
    if (r_live[3:0] != 4'd9) begin
      w_inc[3:0] = r_live[3:0] + 4'd1;
    end else begin
      w_inc[3:0] = 4'd0;
      if (r_live[7:4] != 4'd9) begin
        w_inc[7:4] = r_live[7:4] + 4'd1;
      end else begin
        w_inc[7:4] = 4'd0;
        if (r_live[11:8] != 4'd9) begin
          w_inc[11:8] = r_live[11:8] + 4'd1;
        end else begin
          w_inc[11:8] = 4'd0;
          if (r_live[15:12] != 4'd5) begin
            w_inc[15:12] = r_live[15:12] + 4'd1;
          end else begin
            w_inc[15:12] = 4'd0;
            w_rollover   = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc  <= '0;
      r_live   <= '0;
      r_snap   <= '0;
      r_frozen <= 1'b0;
      r_wrap   <= 1'b0;
    end else if (init_regs) begin
      r_presc  <= '0;
      r_live   <= '0;
      r_snap   <= '0;
      r_frozen <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (count_enabled) begin
        if (w_tick) begin
          r_presc <= '0;
          r_live  <= w_inc;
          r_wrap  <= w_rollover;
        end else begin
          r_presc <= r_presc + c_PW'(1);
        end
        // Snapshot captures the pre-increment value even on a tick edge.
        if (split) begin
          if (!r_frozen) begin
            r_snap   <= r_live;
            r_frozen <= 1'b1;
          end else begin
            r_frozen <= 1'b0;
          end
        end
      end
    end
  end

  assign disp_digits = r_frozen ? r_snap : r_live;
  assign frozen      = r_frozen;
  assign wrap        = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_time_counter.sv
// ============================================================================
// Module   : tb_stopwatch_time_counter
// Brief    : Table vectors, corner sequences and random run against a time model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_time_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        init_regs;
  logic        count_enabled;
  logic        split;
  logic [15:0] disp_digits;
  logic        frozen;
  logic        wrap;

  int checks   = 0;
  int failures = 0;

  stopwatch_time_counter #(
    .CLK_FREQ_HZ (1000),
    .TICK_HZ     (100)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .init_regs     (init_regs),
    .count_enabled (count_enabled),
    .split         (split),
    .disp_digits   (disp_digits),
    .frozen        (frozen),
    .wrap          (wrap)
  );

  always #5 clk = ~clk;

  // Model: elapsed time is just the number of enabled edges since clear.
  int m_edges;
  bit m_frozen;
  int m_snap;
  bit m_wrap;

  function automatic int live_h();
    return (m_edges / 10) % 6000;
  endfunction

  function automatic logic [15:0] to_bcd(input int h);
    return {4'(h / 1000), 4'((h / 100) % 10), 4'((h / 10) % 10), 4'(h % 10)};
  endfunction

  function automatic logic [15:0] model_disp();
    return m_frozen ? to_bcd(m_snap) : to_bcd(live_h());
  endfunction

  task automatic model_clear();
    m_edges  = 0;
    m_frozen = 1'b0;
    m_snap   = 0;
    m_wrap   = 1'b0;
  endtask

  task automatic model_edge();
    if (init_regs) begin
      model_clear();
    end else begin
      m_wrap = 1'b0;
      if (count_enabled) begin
        if (split) begin
          if (!m_frozen) begin
            m_snap   = live_h();
            m_frozen = 1'b1;
          end else begin
            m_frozen = 1'b0;
          end
        end
        m_edges++;
        if ((m_edges % 10 == 0) && (live_h() == 0)) m_wrap = 1'b1;
      end
    end
  endtask

  task automatic check(input string name, input logic [15:0] exp_d,
                       input logic exp_f, input logic exp_w);
    checks++;
    if (disp_digits !== exp_d || frozen !== exp_f || wrap !== exp_w) begin
      failures++;
      $display("FAIL %s: got disp=%h frozen=%b wrap=%b, expected disp=%h frozen=%b wrap=%b",
               name, disp_digits, frozen, wrap, exp_d, exp_f, exp_w);
    end
  endtask

  task automatic check_model(input string name);
    check(name, model_disp(), m_frozen, m_wrap);
  endtask

  // Apply inputs for one edge, update the model, sample 1 time unit later.
  task automatic cycle(input logic i, input logic e, input logic s);
    init_regs     = i;
    count_enabled = e;
    split         = s;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    string       name;
    logic        init;
    logic        en;
    logic        spl;
    int          n;
    logic [15:0] exp_d;
    logic        exp_f;
  } vec_t;

  vec_t vecs[$];
  int   wrap_cnt;

  initial begin
    reset         = 1'b1;
    init_regs     = 1'b0;
    count_enabled = 1'b0;
    split         = 1'b0;
    model_clear();
    #1;
    check("reset_state", 16'h0000, 1'b0, 1'b0);
    #1 reset = 1'b0;

    // split applies on the first edge of a row only
    vecs.push_back('{"init",          1, 0, 0,   1, 16'h0000, 0});
    vecs.push_back('{"count_10",      0, 1, 0,  10, 16'h0001, 0});
    vecs.push_back('{"count_100",     0, 1, 0,  90, 16'h0010, 0});
    vecs.push_back('{"count_1000",    0, 1, 0, 900, 16'h0100, 0});
    vecs.push_back('{"init2",         1, 1, 0,   1, 16'h0000, 0});
    vecs.push_back('{"pause_run25",   0, 1, 0,  25, 16'h0002, 0});
    vecs.push_back('{"pause_hold",    0, 0, 0, 100, 16'h0002, 0});
    vecs.push_back('{"pause_resume5", 0, 1, 0,   5, 16'h0003, 0});
    vecs.push_back('{"init3",         1, 0, 0,   1, 16'h0000, 0});
    vecs.push_back('{"to_0012",       0, 1, 0, 120, 16'h0012, 0});
    vecs.push_back('{"split_freeze",  0, 1, 1,   1, 16'h0012, 1});
    vecs.push_back('{"frozen_run",    0, 1, 0,  79, 16'h0012, 1});
    vecs.push_back('{"split_release", 0, 1, 1,   1, 16'h0020, 0});
    vecs.push_back('{"split_again",   0, 1, 1,   1, 16'h0020, 1});
    vecs.push_back('{"init_priority", 1, 1, 1,   1, 16'h0000, 0});
    vecs.push_back('{"split_zero",    0, 1, 1,   1, 16'h0000, 1});
    vecs.push_back('{"split_paused",  0, 0, 1,   1, 16'h0000, 1});
    vecs.push_back('{"paused_hold",   0, 0, 0,   3, 16'h0000, 1});

    foreach (vecs[v]) begin
      for (int k = 0; k < vecs[v].n; k++)
        cycle(vecs[v].init, vecs[v].en, (k == 0) ? vecs[v].spl : 1'b0);
      check(vecs[v].name, vecs[v].exp_d, vecs[v].exp_f, 1'b0);
    end

    // Async reset between edges at 01.07
    cycle(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 1070; k++) cycle(1'b0, 1'b1, 1'b0);
    check("pre_reset_0107", 16'h0107, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1 check("async_reset", 16'h0000, 1'b0, 1'b0);
    #1 reset = 1'b0;
    model_clear();

    // Full rollover with a single wrap pulse
    cycle(1'b1, 1'b0, 1'b0);
    wrap_cnt = 0;
    for (int k = 1; k <= 60001; k++) begin
      cycle(1'b0, 1'b1, 1'b0);
      if (wrap === 1'b1) wrap_cnt++;
      if (k == 59990) check("at_5999",    16'h5999, 1'b0, 1'b0);
      if (k == 60000) check("rollover",   16'h0000, 1'b0, 1'b1);
      if (k == 60001) check("wrap_drops", 16'h0000, 1'b0, 1'b0);
    end
    checks++;
    if (wrap_cnt != 1) begin
      failures++;
      $display("FAIL wrap_count: got %0d pulses, expected 1", wrap_cnt);
    end

    // Random stimulus against the model
    cycle(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3000; k++) begin
      cycle($urandom_range(99) == 0, $urandom_range(9) < 8, $urandom_range(19) == 0);
      check_model("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
